// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  // RUN: normal flow; REDIR_PEND: corrected target parked in the datapath holding register
  typedef enum logic [0:0] {
    RUN        = 1'b0,
    REDIR_PEND = 1'b1
  } pipe_ctrl_state_t;

  // redirect_src encodings for the PC mux
  localparam logic REDIR_SRC_DEC  = 1'b0;
  localparam logic REDIR_SRC_HOLD = 1'b1;

  // Bits needed to hold a count of 0..max
  function automatic int wait_cnt_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Latency: count updates on the rising edge after inc_i/clr_i.
// Backpressure: none; holds at MAX until cleared or reset.
module sat_counter #(
  parameter int             W   = 8,
  parameter logic [W-1:0]   MAX = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // next count: clear, increment below the ceiling, or hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/redirect sequencer for the 5-stage pipeline; optional perf counters under PIPE_CTRL_PERF_EN.
// Latency: all controls combinational from state and inputs; state/counters/timeout update on clk rise.
// Backpressure: dmem_busy freezes everything; a mispredict seen while imem_busy is parked until fetch is ready.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             hazard_stall,
  input  logic             mispredict_d,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  output logic             en_f,
  output logic             en_d,
  output logic             en_x,
  output logic             en_m,
  output logic             en_w,
  output logic             flush_d,
  output logic             flush_x,
  output logic             redirect,
  output logic             redirect_src,
  output logic             tgt_load,
  output logic             wait_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = wait_cnt_width(MAX_WAIT);

  pipe_ctrl_state_t state_q, state_d;
  logic             timeout_q, timeout_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic             wait_hit;

  // ungated control values; forced to 0 below while reset is asserted
  logic en_f_c, en_d_c, en_x_c, en_m_c, en_w_c;
  logic flush_d_c, flush_x_c, redirect_c, redirect_src_c, tgt_load_c;

  // state register; reset drops any parked redirect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // next state: dmem freeze holds; hazard in RUN blocks the mispredict from being taken
  always_comb begin
    state_d = state_q;
    if (!dmem_busy) begin
      case (state_q)
        RUN:        if (!hazard_stall && imem_busy && mispredict_d) state_d = REDIR_PEND;
        REDIR_PEND: if (!imem_busy) state_d = RUN;
        default:    state_d = RUN;
      endcase
    end
  end

  // control outputs, priority dmem_busy > hazard_stall > imem_busy > mispredict_d
  always_comb begin
    en_f_c         = 1'b1;
    en_d_c         = 1'b1;
    en_x_c         = 1'b1;
    en_m_c         = 1'b1;
    en_w_c         = 1'b1;
    flush_d_c      = 1'b0;
    flush_x_c      = 1'b0;
    redirect_c     = 1'b0;
    redirect_src_c = REDIR_SRC_DEC;
    tgt_load_c     = 1'b0;
    if (dmem_busy) begin
      // the branch stays in D and re-presents once memory completes
      en_f_c = 1'b0;
      en_d_c = 1'b0;
      en_x_c = 1'b0;
      en_m_c = 1'b0;
      en_w_c = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (hazard_stall) begin
            // branch operands are not valid under a stall, so mispredict is not trusted
            en_f_c    = 1'b0;
            en_d_c    = 1'b0;
            flush_x_c = 1'b1;
          end else if (imem_busy) begin
            en_f_c     = 1'b0;
            flush_d_c  = 1'b1;
            tgt_load_c = mispredict_d;
          end else if (mispredict_d) begin
            redirect_c     = 1'b1;
            redirect_src_c = REDIR_SRC_DEC;
            flush_d_c      = 1'b1;
          end
        end
        REDIR_PEND: begin
          // D holds only bubbles here, so hazard_stall has nothing to protect
          flush_d_c = 1'b1;
          if (imem_busy) begin
            en_f_c = 1'b0;
          end else begin
            redirect_c     = 1'b1;
            redirect_src_c = REDIR_SRC_HOLD;
          end
        end
        default: ;
      endcase
    end
  end

  assign en_f         = en_f_c         & reset_n;
  assign en_d         = en_d_c         & reset_n;
  assign en_x         = en_x_c         & reset_n;
  assign en_m         = en_m_c         & reset_n;
  assign en_w         = en_w_c         & reset_n;
  assign flush_d      = flush_d_c      & reset_n;
  assign flush_x      = flush_x_c      & reset_n;
  assign redirect     = redirect_c     & reset_n;
  assign redirect_src = redirect_src_c & reset_n;
  assign tgt_load     = tgt_load_c     & reset_n;

  // consecutive dmem_busy cycles, saturating at MAX_WAIT
  sat_counter #(
    .W   (WAIT_W),
    .MAX (WAIT_W'(MAX_WAIT))
  ) u_wait_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .clr_i (!dmem_busy),
    .inc_i (dmem_busy),
    .cnt_o (wait_cnt)
  );

  // this busy cycle is the MAX_WAIT-th in a row (or later)
  assign wait_hit  = dmem_busy && (wait_cnt >= WAIT_W'(MAX_WAIT - 1));
  assign timeout_d = timeout_q | wait_hit;

  // sticky timeout flag, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign wait_timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
  // cycles where fetch did not advance
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .clr_i (1'b0),
    .inc_i (!en_f),
    .cnt_o (stall_cycles)
  );

  // cycles where the PC was redirected
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .clr_i (1'b0),
    .inc_i (redirect),
    .cnt_o (flush_count)
  );
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl (MAX_WAIT=4).
// Expected control vectors are queued as stimulus is applied and popped at the following negedge.
// Perf counter expectations come from a bench-side count of queued vectors.
module tb_pipeline_ctrl;

  // control vector bit order: en_f en_d en_x en_m en_w flush_d flush_x redirect redirect_src tgt_load
  localparam logic [9:0] E_DEF   = 10'b11111_0_0_0_0_0;
  localparam logic [9:0] E_FRZ   = 10'b00000_0_0_0_0_0;
  localparam logic [9:0] E_MISP  = 10'b11111_1_0_1_0_0;
  localparam logic [9:0] E_HAZ   = 10'b00111_0_1_0_0_0;
  localparam logic [9:0] E_IMEM  = 10'b01111_1_0_0_0_0;
  localparam logic [9:0] E_TGT   = 10'b01111_1_0_0_0_1;
  localparam logic [9:0] E_HOLD  = 10'b11111_1_0_1_1_0;

  typedef struct packed {
    logic       hs;
    logic       mp;
    logic       ib;
    logic       db;
    logic [9:0] e;
    logic       wt;
  } step_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        hazard_stall, mispredict_d, imem_busy, dmem_busy;
  logic        en_f, en_d, en_x, en_m, en_w;
  logic        flush_d, flush_x, redirect, redirect_src, tgt_load;
  logic        wait_timeout;
  logic [31:0] stall_cycles, flush_count;
  logic [9:0]  outs;

  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned exp_stall = 0;
  int unsigned exp_flush = 0;
  logic [9:0]  exp_q[$];

  always #5 clk = ~clk;

  assign outs = {en_f, en_d, en_x, en_m, en_w, flush_d, flush_x, redirect, redirect_src, tgt_load};

  pipeline_ctrl #(.MAX_WAIT(4), .CNT_W(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .hazard_stall (hazard_stall),
    .mispredict_d (mispredict_d),
    .imem_busy    (imem_busy),
    .dmem_busy    (dmem_busy),
    .en_f         (en_f),
    .en_d         (en_d),
    .en_x         (en_x),
    .en_m         (en_m),
    .en_w         (en_w),
    .flush_d      (flush_d),
    .flush_x      (flush_x),
    .redirect     (redirect),
    .redirect_src (redirect_src),
    .tgt_load     (tgt_load),
    .wait_timeout (wait_timeout),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  // drive one cycle of inputs just after the edge and queue its expected controls
  task automatic run_step(input step_t s);
    @(posedge clk);
    #1;
    hazard_stall = s.hs;
    mispredict_d = s.mp;
    imem_busy    = s.ib;
    dmem_busy    = s.db;
    exp_q.push_back(s.e);
    if (!s.e[9]) exp_stall++;
    if (s.e[2])  exp_flush++;
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    hazard_stall = 1'b0;
    mispredict_d = 1'b1;
    imem_busy    = 1'b1;
    dmem_busy    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (outs !== 10'b0) begin
      n_err++; $display("FAIL reset_outs: got %b want %b", outs, 10'b0);
    end
    n_cmp++;
    if ({wait_timeout, stall_cycles, flush_count} !== 65'b0) begin
      n_err++; $display("FAIL reset_state: got wt=%b stall=%0d flush=%0d want 0", wait_timeout, stall_cycles, flush_count);
    end
    mispredict_d = 1'b0;
    imem_busy    = 1'b0;
    reset_n      = 1'b1;
    exp_stall    = 0;
    exp_flush    = 0;
  endtask

  task automatic test_lone_mispredict();
    step_t tbl[3];
    logic [9:0] e;
    logic [31:0] ws, wf;
    tbl = '{'{0,1,0,0,E_MISP,0}, '{0,0,0,0,E_DEF,0}, '{0,0,0,0,E_DEF,0}};
    foreach (tbl[i]) begin
      run_step(tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (outs !== e) begin
        n_err++; $display("FAIL lone_misp[%0d]: got %b want %b", i, outs, e);
      end
    end
`ifdef PIPE_CTRL_PERF_EN
    ws = exp_stall; wf = exp_flush;
`else
    ws = 0; wf = 0;
`endif
    n_cmp++;
    if (flush_count !== wf || stall_cycles !== ws) begin
      n_err++; $display("FAIL lone_misp_cnt: got stall=%0d flush=%0d want stall=%0d flush=%0d", stall_cycles, flush_count, ws, wf);
    end
  endtask

  task automatic test_hazard_mispredict();
    step_t tbl[6];
    logic [9:0] e;
    tbl = '{'{1,1,0,0,E_HAZ,0}, '{1,0,0,0,E_HAZ,0}, '{0,0,0,0,E_DEF,0},
            '{1,1,1,0,E_HAZ,0}, '{0,0,0,0,E_DEF,0}, '{0,0,1,0,E_IMEM,0}};
    foreach (tbl[i]) begin
      run_step(tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (outs !== e) begin
        n_err++; $display("FAIL hazard_misp[%0d]: got %b want %b", i, outs, e);
      end
    end
  endtask

  task automatic test_fetch_wait();
    step_t tbl[6];
    logic [9:0] e;
    logic [31:0] ws, wf;
    // cycle 1 also raises hazard_stall, which must not matter while a redirect is parked
    tbl = '{'{0,1,1,0,E_TGT,0}, '{1,1,1,0,E_IMEM,0}, '{0,1,1,0,E_IMEM,0},
            '{0,0,0,0,E_HOLD,0}, '{0,0,0,0,E_DEF,0}, '{0,0,0,0,E_DEF,0}};
    foreach (tbl[i]) begin
      run_step(tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (outs !== e) begin
        n_err++; $display("FAIL fetch_wait[%0d]: got %b want %b", i, outs, e);
      end
    end
`ifdef PIPE_CTRL_PERF_EN
    ws = exp_stall; wf = exp_flush;
`else
    ws = 0; wf = 0;
`endif
    n_cmp++;
    if (flush_count !== wf || stall_cycles !== ws) begin
      n_err++; $display("FAIL fetch_wait_cnt: got stall=%0d flush=%0d want stall=%0d flush=%0d", stall_cycles, flush_count, ws, wf);
    end
  endtask

  task automatic test_freeze_pending();
    step_t tbl[8];
    logic [9:0] e;
    tbl = '{'{0,1,1,0,E_TGT,0}, '{1,1,0,1,E_FRZ,0}, '{0,0,0,1,E_FRZ,0},
            '{0,0,1,0,E_IMEM,0}, '{0,0,0,0,E_HOLD,0}, '{0,1,0,1,E_FRZ,0},
            '{0,0,0,0,E_DEF,0}, '{0,0,0,0,E_DEF,0}};
    foreach (tbl[i]) begin
      run_step(tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (outs !== e || wait_timeout !== tbl[i].wt) begin
        n_err++; $display("FAIL freeze_pend[%0d]: got %b wt=%b want %b wt=%b", i, outs, wait_timeout, e, tbl[i].wt);
      end
    end
  endtask

  task automatic test_timeout();
    step_t tbl[14];
    logic [9:0] e;
    tbl = '{'{0,0,0,1,E_FRZ,0}, '{0,0,0,1,E_FRZ,0}, '{0,0,0,1,E_FRZ,0},
            '{0,0,0,0,E_DEF,0},
            '{0,0,0,1,E_FRZ,0}, '{0,0,0,1,E_FRZ,0}, '{0,0,0,1,E_FRZ,0},
            '{0,0,0,0,E_DEF,0},
            '{0,0,0,1,E_FRZ,0}, '{0,0,0,1,E_FRZ,0}, '{0,0,0,1,E_FRZ,0}, '{0,0,0,1,E_FRZ,0},
            '{0,0,0,0,E_DEF,1}, '{0,0,0,0,E_DEF,1}};
    foreach (tbl[i]) begin
      run_step(tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (outs !== e || wait_timeout !== tbl[i].wt) begin
        n_err++; $display("FAIL timeout[%0d]: got %b wt=%b want %b wt=%b", i, outs, wait_timeout, e, tbl[i].wt);
      end
    end
  endtask

  task automatic test_reset_mid_recovery();
    step_t s;
    logic [9:0] e;
    logic [31:0] ws, wf;
    s = '{0,1,1,0,E_TGT,0};
    run_step(s);
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if (outs !== e) begin
      n_err++; $display("FAIL rst_mid_enter: got %b want %b", outs, e);
    end
    // now parked in REDIR_PEND; fetch becomes ready, then reset hits mid-cycle
    @(posedge clk);
    #1;
    mispredict_d = 1'b0;
    imem_busy    = 1'b0;
    #1;
    n_cmp++;
    if (outs !== E_HOLD) begin
      n_err++; $display("FAIL rst_mid_pending: got %b want %b", outs, E_HOLD);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (outs !== 10'b0 || wait_timeout !== 1'b0 || stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
      n_err++; $display("FAIL rst_mid_async: got %b wt=%b stall=%0d flush=%0d want all 0", outs, wait_timeout, stall_cycles, flush_count);
    end
    @(negedge clk);
    reset_n   = 1'b1;
    exp_stall = 0;
    exp_flush = 0;
    for (int i = 0; i < 2; i++) begin
      s = '{0,0,0,0,E_DEF,0};
      run_step(s);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (outs !== e) begin
        n_err++; $display("FAIL rst_mid_after[%0d]: got %b want %b", i, outs, e);
      end
    end
`ifdef PIPE_CTRL_PERF_EN
    ws = exp_stall; wf = exp_flush;
`else
    ws = 0; wf = 0;
`endif
    n_cmp++;
    if (flush_count !== wf || stall_cycles !== ws) begin
      n_err++; $display("FAIL rst_mid_cnt: got stall=%0d flush=%0d want stall=%0d flush=%0d", stall_cycles, flush_count, ws, wf);
    end
  endtask

  initial begin
    test_reset();
    test_lone_mispredict();
    test_hazard_mispredict();
    test_fetch_wait();
    test_freeze_pending();
    test_timeout();
    test_reset_mid_recovery();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage pipeline with dynamic branch prediction. It merges three inputs: the hazard-detection stall request, decode-stage branch mispredict resolution, and the instruction- and data-memory busy handshakes. From these it produces per-stage register enables, bubble/flush controls and PC-redirect controls. It also holds a mispredict redirect pending while fetch is busy, and it flags stuck data-memory accesses.

## Interface
Parameters:
- MAX_WAIT, 64: consecutive dmem_busy cycles that set wait_timeout (≥1).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  reset; asynchronous, active-low
- hazard_stall  in  1  load-use/branch-operand stall from the hazard unit
- mispredict_d  in  1  decode-stage branch resolved against its prediction
- imem_busy  in  1  fetch memory delivers no instruction this cycle
- dmem_busy  in  1  M-stage data access not complete this cycle
- en_f, en_d, en_x, en_m, en_w  out  1 each  stage register enables (PC, D, X, M, W)
- flush_d, flush_x  out  1 each  load a bubble into the D / X register at the edge
- redirect  out  1  PC mux takes the corrected target this cycle
- redirect_src  out  1  0 = live decode target, 1 = datapath holding register
- tgt_load  out  1  datapath captures the decode corrected target into the holding register
- wait_timeout  out  1  sticky: dmem_busy high for MAX_WAIT consecutive cycles
- stall_cycles  out  CNT_W  perf counter (see Configuration)
- flush_count  out  CNT_W  perf counter (see Configuration)

## Operation
- FSM states: RUN and REDIR_PEND. Outputs are combinational from the state and the inputs.
- Default outputs are: all enables 1, all other controls 0.
- Priority each cycle: dmem_busy > hazard_stall > imem_busy > mispredict_d.
- Freeze (dmem_busy=1, either state):
  - All enables 0; no flush, redirect or tgt_load.
  - State is held.
  - mispredict_d is ignored, because the branch stays in D and re-presents.
- RUN, hazard_stall=1:
  - en_f=en_d=0, flush_x=1.
  - mispredict_d is ignored, because branch operands are not valid under a stall.
- RUN, imem_busy=1:
  - en_f=0, flush_d=1 (bubble into D).
  - If mispredict_d=1 in the same cycle: tgt_load=1, then → REDIR_PEND.
- RUN, mispredict_d alone: redirect=1, redirect_src=0, flush_d=1. State stays RUN.
- REDIR_PEND, imem_busy=1: en_f=0, flush_d=1. hazard_stall is ignored because D holds only bubbles.
- REDIR_PEND, imem_busy=0: redirect=1, redirect_src=1, flush_d=1, then → RUN.
- Wait counter:
  - Counts consecutive dmem_busy cycles and saturates at MAX_WAIT.
  - Clears on any cycle with dmem_busy=0.
  - wait_timeout sets when the count reaches MAX_WAIT and stays set until reset.

## Timing
- All outputs react in the same cycle. State, counters and wait_timeout update on the rising clk edge.
- Redirect latency:
  - 0 cycles after mispredict_d when fetch is ready.
  - Otherwise, the first cycle with imem_busy=0 and dmem_busy=0 after entering REDIR_PEND.
- wait_timeout rises on the edge ending the MAX_WAIT-th consecutive busy cycle.
- Reset, asynchronous, including mid-recovery:
  - State → RUN; counters and wait_timeout → 0; any pending redirect is dropped.
  - While reset_n=0, every output is 0, including all enables.

## Configuration
- With PIPE_CTRL_PERF_EN defined:
  - stall_cycles increments on every cycle with en_f=0.
  - flush_count increments on every cycle with redirect=1.
  - Both counters saturate at all-ones.
- Without the macro: both ports are tied to 0, no counter logic is built, and the port list is unchanged.

## Structure
- Package pipe_ctrl_pkg holds:
  - state enum pipe_ctrl_state_t {RUN, REDIR_PEND};
  - the redirect_src encodings REDIR_SRC_DEC / REDIR_SRC_HOLD.
- Sub-module sat_counter (parameterised width, clear, increment, saturate) is used for the wait counter and both perf counters.

## Test plan
- Lone mispredict: mispredict_d=1 for 1 cycle in RUN → same cycle redirect=1, redirect_src=0, flush_d=1, all enables 1; flush_count=1.
- Hazard plus mispredict: hazard_stall=1 and mispredict_d=1 together → en_f=en_d=0, flush_x=1, redirect=0.
- Mispredict during fetch wait: mispredict_d=1 with imem_busy=1 for 3 cycles → tgt_load=1 in cycle 0 only; flush_d=1 in cycles 0–3; redirect=1 with redirect_src=1 in cycle 3; state RUN afterwards.
- Freeze during pending redirect: enter REDIR_PEND, then dmem_busy=1 for 2 cycles → all enables 0, no redirect; redirect fires once dmem_busy=0 and imem_busy=0.
- Timeout: MAX_WAIT=4, dmem_busy=1 for 4 cycles → wait_timeout=1 after the 4th edge and held after dmem_busy falls. A run of 3 busy cycles, a gap, then 3 more → wait_timeout stays 0.
- Reset mid-recovery: reset_n pulsed low in REDIR_PEND → outputs all 0 immediately; after release, imem_busy=0 yields no redirect; with PIPE_CTRL_PERF_EN, counters read 0.
